// File: rtl/tcp_tx_serializer.sv
// tcp_tx_serializer: 32-bit word FIFO plus hold stage feeding SiTCP TX bytes, LSB first.
// Optional macro TCP_TX_FLUSH_ON_CLOSE_EN: discard queued data when the connection closes.
module tcp_tx_serializer #(
    parameter int DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        WRITE,
    input  logic [31:0] DATA_IN,
    output logic        READY,
    input  logic        USR_ACTIVE,
    input  logic        USR_TX_AFULL,
    output logic        USR_TX_WE,
    output logic [7:0]  USR_TX_WD,
    output logic        EMPTY,
    output logic        OVERFLOW,
    output logic [31:0] BYTE_CNT
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

`ifdef TCP_TX_FLUSH_ON_CLOSE_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_FLUSH} state_t;
`else
    typedef enum logic {S_IDLE, S_SEND} state_t;
`endif

    state_t        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   hold_q, hold_d;
    logic          valid_q, valid_d;
    logic [1:0]    idx_q, idx_d;
    logic          we_q, we_d;
    logic [7:0]    wd_q, wd_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic ready;
    logic push;
    logic pop;
    logic send_ok;
    logic fifo_nempty;
    logic flushing;
    logic close;

`ifdef TCP_TX_FLUSH_ON_CLOSE_EN
    logic act_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            act_q <= 1'b0;
        end else begin
            act_q <= USR_ACTIVE;
        end
    end

    assign close    = act_q && !USR_ACTIVE;
    assign flushing = (state_q == S_FLUSH);
`else
    assign close    = 1'b0;
    assign flushing = 1'b0;
`endif

    assign ready       = (count_q < FULL_CNT);
    assign fifo_nempty = (count_q != '0);
    assign push        = WRITE && ready && !flushing;
    assign send_ok     = USR_ACTIVE && !USR_TX_AFULL;
    assign ovf_d       = ovf_q || (WRITE && !ready && !flushing);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flushing) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    valid_d = 1'b1;
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (send_ok) begin
                    we_d  = 1'b1;
                    wd_d  = hold_q[{idx_q, 3'b000} +: 8];
                    idx_d = idx_q + 2'd1;
                    cnt_d = cnt_q + 32'd1;
                    // Last byte: reload straight from the FIFO so there is no bubble.
                    if (idx_q == 2'd3) begin
                        if (fifo_nempty) begin
                            pop    = 1'b1;
                            hold_d = mem_q[rd_ptr_q];
                        end else begin
                            valid_d = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
`ifdef TCP_TX_FLUSH_ON_CLOSE_EN
            S_FLUSH: begin
                valid_d = 1'b0;
                idx_d   = 2'd0;
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (close) begin
            state_d = state_t'(2);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            valid_q  <= 1'b0;
            idx_q    <= 2'd0;
            we_q     <= 1'b0;
            wd_q     <= 8'd0;
            cnt_q    <= 32'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            wd_q     <= wd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign READY     = ready;
    assign EMPTY     = !fifo_nempty && !valid_q;
    assign USR_TX_WE = we_q;
    assign USR_TX_WD = wd_q;
    assign OVERFLOW  = ovf_q;
    assign BYTE_CNT  = cnt_q;

endmodule
